dma_rd_tag_scheduler: RTL

//  Host-to-card (s2c) DMA read scheduler. Accepts one read command (address, byte length), splits it into

---
 rtl/dma_pkg.sv | 17 +
 rtl/dma_tag_pick.sv | 25 ++
 rtl/dma_rd_tag_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: tag/length widths, 4 KB boundary and the
// read-scheduler state encoding.
package dma_pkg;

   localparam int C_TAG_W    = 8;
   localparam int C_DW_LEN_W = 11;
   localparam int C_4K_BYTES = 4096;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SPLIT    = 3'd1,
      ST_WAIT_TAG = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_DRAIN    = 3'd4
   } dma_state_t;

endpackage

// File: rtl/dma_tag_pick.sv
// Lowest-index free tag finder over a free-tag mask. Shared by the s2c and
// c2s schedulers.
module dma_tag_pick
   import dma_pkg::*;
#(
   parameter int C_N = 16
) (
   input  logic [C_N-1:0]     i_free,
   output logic               o_found,
   output logic [C_TAG_W-1:0] o_index
);

   // Scan from the top down so the lowest set bit is the last to win.
   always_comb begin
      o_found = 1'b0;
      o_index = '0;
      for (int i = C_N - 1; i >= 0; i--) begin
         if (i_free[i]) begin
            o_found = 1'b1;
            o_index = C_TAG_W'(i);
         end
      end
   end

endmodule

// File: rtl/dma_rd_tag_scheduler.sv
// Host-to-card DMA read scheduler: splits one read command into 4 KB-safe,
// max-read-request-sized memory reads and tags each from a fixed pool.
module dma_rd_tag_scheduler
   import dma_pkg::*;
#(
   parameter int C_WINDOW_SIZE           = 16,
   parameter int C_LOG2_MAX_READ_REQUEST = 12
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_cmd_valid,
   output logic                               o_cmd_ready,
   input  logic [63:0]                        i_cmd_addr,
   input  logic [31:0]                        i_cmd_bytes,
   output logic                               o_cmd_done,
   output logic                               o_rq_valid,
   input  logic                               i_rq_ready,
   output logic [63:0]                        o_rq_addr,
   output logic [C_DW_LEN_W-1:0]              o_rq_dwords,
   output logic [C_TAG_W-1:0]                 o_rq_tag,
   output logic [C_WINDOW_SIZE-1:0]           o_busy_tags,
   output logic [C_WINDOW_SIZE*C_DW_LEN_W-1:0] o_size_tags,
   input  logic [C_WINDOW_SIZE-1:0]           i_completed_tags,
   input  logic [63:0]                        i_current_window_size,
   output logic [8:0]                         o_outstanding,
   output logic                               o_err_spurious
);

   localparam int C_MAX_DW = 2 ** (C_LOG2_MAX_READ_REQUEST - 2);

   dma_state_t                r_state;
   logic [63:0]               r_addr;
   logic [29:0]               r_rem_dw;
   logic [C_DW_LEN_W-1:0]     r_chunk;
   logic [C_TAG_W-1:0]        r_tag;
   logic                      r_cmd_ready;
   logic                      r_cmd_done;
   logic                      r_rq_valid;
   logic [C_WINDOW_SIZE-1:0]  r_busy;
   logic [C_DW_LEN_W-1:0]     r_size [C_WINDOW_SIZE];
   logic                      r_err;

   logic                      w_found;
   logic [C_TAG_W-1:0]        w_pick;
   logic                      w_rq_hs;
   logic [C_WINDOW_SIZE-1:0]  w_alloc;
   logic [C_WINDOW_SIZE-1:0]  w_free_hit;
   logic [8:0]                w_outstanding;
   logic [8:0]                w_eff_win;
   logic [12:0]               w_dist_4k;
   logic [C_DW_LEN_W-1:0]     w_to_4k_dw;
   logic [29:0]               w_chunk_wide;
   logic                      w_unused;

   dma_tag_pick #(.C_N(C_WINDOW_SIZE)) u_pick (
      .i_free  (~r_busy),
      .o_found (w_found),
      .o_index (w_pick)
   );

   assign w_rq_hs    = r_rq_valid & i_rq_ready;
   assign w_free_hit = i_completed_tags & r_busy;

   // Bytes left before the next 4 KB page; address is DW aligned.
   assign w_dist_4k  = 13'(C_4K_BYTES) - {1'b0, r_addr[11:0]};
   assign w_to_4k_dw = w_dist_4k[12:2];

   // Runtime window: zero or oversize means "use the whole pool".
   assign w_eff_win = ((i_current_window_size == 64'd0) ||
                       (i_current_window_size > 64'(C_WINDOW_SIZE)))
                      ? 9'(C_WINDOW_SIZE) : i_current_window_size[8:0];

   // Chunk is the smallest of remaining length, max read request and page room.
   always_comb begin
      w_chunk_wide = r_rem_dw;
      if (w_chunk_wide > 30'(C_MAX_DW))
         w_chunk_wide = 30'(C_MAX_DW);
      if (w_chunk_wide > {19'd0, w_to_4k_dw})
         w_chunk_wide = {19'd0, w_to_4k_dw};
   end

   // Popcount of busy tags and one-hot of the tag being allocated.
   always_comb begin
      w_outstanding = '0;
      w_alloc       = '0;
      for (int j = 0; j < C_WINDOW_SIZE; j++) begin
         w_outstanding = w_outstanding + 9'(r_busy[j]);
         w_alloc[j]    = w_rq_hs && (r_tag == C_TAG_W'(j));
      end
   end

   assign w_unused = ^{i_cmd_bytes[1:0], w_dist_4k[1:0], w_chunk_wide[29:11]};

   // Command FSM: latch, split, wait for a tag, issue, then drain completions.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_rem_dw    <= '0;
         r_chunk     <= '0;
         r_tag       <= '0;
         r_cmd_ready <= 1'b1;
         r_cmd_done  <= 1'b0;
         r_rq_valid  <= 1'b0;
      end else begin
         r_cmd_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  r_addr      <= i_cmd_addr;
                  r_rem_dw    <= i_cmd_bytes[31:2];
                  r_cmd_ready <= 1'b0;
                  r_state     <= ST_SPLIT;
               end
            end
            ST_SPLIT: begin
               r_chunk <= w_chunk_wide[C_DW_LEN_W-1:0];
               r_state <= ST_WAIT_TAG;
            end
            ST_WAIT_TAG: begin
               if (w_found && (w_outstanding < w_eff_win)) begin
                  r_tag      <= w_pick;
                  r_rq_valid <= 1'b1;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (i_rq_ready) begin
                  r_rq_valid <= 1'b0;
                  r_addr     <= r_addr + {51'd0, r_chunk, 2'b00};
                  r_rem_dw   <= r_rem_dw - {19'd0, r_chunk};
                  r_state    <= (r_rem_dw == {19'd0, r_chunk}) ? ST_DRAIN : ST_SPLIT;
               end
            end
            ST_DRAIN: begin
               if (r_busy == '0) begin
                  r_cmd_done  <= 1'b1;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Tag pool: set on issue handshake, clear on completion, flag stray completions.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy <= '0;
         r_err  <= 1'b0;
      end else begin
         r_busy <= (r_busy & ~w_free_hit) | w_alloc;
         if ((i_completed_tags & ~r_busy) != '0)
            r_err <= 1'b1;
      end
   end

   // Per-tag DW size, written on allocation and held after the tag frees.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int j = 0; j < C_WINDOW_SIZE; j++)
            r_size[j] <= '0;
      end else begin
         for (int j = 0; j < C_WINDOW_SIZE; j++)
            if (w_alloc[j])
               r_size[j] <= r_chunk;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < C_WINDOW_SIZE; gi++) begin : g_size
         assign o_size_tags[C_DW_LEN_W*gi +: C_DW_LEN_W] = r_size[gi];
      end
   endgenerate

   assign o_cmd_ready    = r_cmd_ready;
   assign o_cmd_done     = r_cmd_done;
   assign o_rq_valid     = r_rq_valid;
   assign o_rq_addr      = r_addr;
   assign o_rq_dwords    = r_chunk;
   assign o_rq_tag       = r_tag;
   assign o_busy_tags    = r_busy;
   assign o_outstanding  = w_outstanding;
   assign o_err_spurious = r_err;

endmodule
